// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit
//   Multi-cycle integer divider for the EX stage (DIV / DIVU). It uses radix-2
//   restoring trial subtraction and does one quotient bit per clock.
//   The result is packed as {remainder, quotient}. The pipeline later writes
//   it as hi = remainder, lo = quotient.
//
// Ports
//   clk           clock; all state changes on the rising edge
//   rst           synchronous, active-high reset
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
//   opdata1_i     dividend; sampled with start_i
//   opdata2_i     divisor; sampled with start_i
//   start_i       request; EX holds it high until it has taken the result
//   annul_i       flush; aborts a division that is iterating
//   result_o      {remainder, quotient}; meaningful only while ready_o = 1
//   ready_o       result valid
// ----------------------------------------------------------------------------
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    S_FREE,
    S_BY_ZERO,
    S_ON,
    S_END
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [DATA_W-1:0]    rem_reg, rem_next;
  logic [DATA_W-1:0]    quo_reg, quo_next;
  logic [DATA_W-1:0]    divisor_reg, divisor_next;
  logic                 neg_quo_reg, neg_quo_next;
  logic                 neg_rem_reg, neg_rem_next;
  logic [2*DATA_W-1:0]  result_reg, result_next;
  logic                 ready_reg, ready_next;

  // Partial remainder shifted left, with the next dividend bit brought in.
  // It needs one extra bit because 2*rem + 1 can reach 2*divisor - 1.
  // The trial subtraction gets one further bit so its MSB acts as the borrow.
  logic [DATA_W:0]      shifted;
  logic [DATA_W+1:0]    trial;
  logic                 dvd_neg, dvs_neg;
  logic [DATA_W-1:0]    dvd_abs, dvs_abs;
  logic [DATA_W-1:0]    rem_fix, quo_fix;

  always_comb begin
    shifted = {rem_reg, quo_reg[DATA_W-1]};
    trial   = {1'b0, shifted} - {2'b00, divisor_reg};

    dvd_neg = signed_div_i & opdata1_i[DATA_W-1];
    dvs_neg = signed_div_i & opdata2_i[DATA_W-1];
    // Negating -2^(W-1) gives back the same bit pattern. Read as unsigned,
    // that is the correct magnitude, so the most-negative case needs no
    // special handling here.
    dvd_abs = dvd_neg ? -opdata1_i : opdata1_i;
    dvs_abs = dvs_neg ? -opdata2_i : opdata2_i;

    rem_fix = neg_rem_reg ? -rem_reg : rem_reg;
    quo_fix = neg_quo_reg ? -quo_reg : quo_reg;
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    rem_next     = rem_reg;
    quo_next     = quo_reg;
    divisor_next = divisor_reg;
    neg_quo_next = neg_quo_reg;
    neg_rem_next = neg_rem_reg;
    result_next  = result_reg;
    ready_next   = ready_reg;

    unique case (state_reg)
      S_FREE: begin
        result_next = '0;
        ready_next  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_next = S_BY_ZERO;
          end else begin
            state_next   = S_ON;
            cnt_next     = '0;
            rem_next     = '0;
            // The quotient register starts out holding the dividend. It is
            // shifted out from the top while quotient bits enter at the bottom.
            quo_next     = dvd_abs;
            divisor_next = dvs_abs;
            neg_quo_next = dvd_neg ^ dvs_neg;
            neg_rem_next = dvd_neg;
          end
        end
      end

      S_BY_ZERO: begin
        state_next  = S_END;
        result_next = '0;
        ready_next  = 1'b1;
      end

      S_ON: begin
        if (annul_i) begin
          state_next  = S_FREE;
          result_next = '0;
          ready_next  = 1'b0;
        end else if (cnt_reg != CNT_DONE) begin
          // A borrow (MSB set) means the trial went negative: restore the
          // remainder and shift in a 0 quotient bit.
          if (trial[DATA_W+1]) begin
            rem_next = shifted[DATA_W-1:0];
          end else begin
            rem_next = trial[DATA_W-1:0];
          end
          quo_next = {quo_reg[DATA_W-2:0], ~trial[DATA_W+1]};
          cnt_next = cnt_reg + 1'b1;
        end else begin
          state_next  = S_END;
          result_next = {rem_fix, quo_fix};
          ready_next  = 1'b1;
        end
      end

      S_END: begin
        if (!start_i) begin
          state_next  = S_FREE;
          result_next = '0;
          ready_next  = 1'b0;
        end
      end

      default: begin
        state_next  = S_FREE;
        result_next = '0;
        ready_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_FREE;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      divisor_reg <= '0;
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      result_reg  <= '0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rem_reg     <= rem_next;
      quo_reg     <= quo_next;
      divisor_reg <= divisor_next;
      neg_quo_reg <= neg_quo_next;
      neg_rem_reg <= neg_rem_next;
      result_reg  <= result_next;
      ready_reg   <= ready_next;
    end
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_unit.sv
// ----------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit. It applies three kinds of stimulus:
//   - a table of directed vectors;
//   - hand-written annul and reset sequences;
//   - randomized divisions checked against an arithmetic reference model.
//   Latency is counted in falling edges after the edge that samples start_i.
// ----------------------------------------------------------------------------
module tb_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          signed_div_i;
  logic [W-1:0]  opdata1_i;
  logic [W-1:0]  opdata2_i;
  logic          start_i;
  logic          annul_i;
  logic [2*W-1:0] result_o;
  logic          ready_o;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  div_unit #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [63:0]  res;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  // Reference model. It uses plain arithmetic with truncation toward zero,
  // and the remainder takes the sign of the dividend.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb, q, r;
    if (b == '0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  function automatic int ref_lat(input logic [W-1:0] b);
    return (b == '0) ? 2 : W + 2;
  endfunction

  // Runs one full transaction. It starts at a falling edge and returns at a
  // falling edge with the DUT back in idle.
  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold);
    logic [63:0] exp_res;
    int          exp_lat, lat;
    logic [63:0] got_res;
    exp_res = ref_div(sgn, a, b);
    exp_lat = ref_lat(b);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    // The operands were latched; changing them now must have no effect.
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sgn;
    lat = -1;
    for (int k = 1; k <= W + 8; k++) begin
      @(negedge clk);
      if (ready_o) begin
        lat = k;
        break;
      end
    end
    got_res = result_o;
    txn++;
    $display("txn %0d sgn=%0d a=%h b=%h res=%h lat=%0d", txn, sgn, a, b, got_res, lat);
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", got_res, exp_res);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_ready", {63'd0, ready_o}, 64'd1);
      check("hold_result", result_o, exp_res);
    end
    start_i = 1'b0;
    @(negedge clk);
    check("drop_ready", {63'd0, ready_o}, 64'd0);
    check("drop_result", result_o, 64'd0);
  endtask

  vec_t vecs[10];
  int   ready_seen;
  logic sgn_r;
  logic [W-1:0] a_r, b_r;

  initial begin
    vecs[0] = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 34};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},  34};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},          34};
    vecs[3] = '{1'b1, 32'h1234,       32'd0,          64'd0,                           2};
    vecs[4] = '{1'b0, 32'h1234,       32'd0,          64'd0,                           2};
    vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0, 32'h8000_0000},          34};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0, 32'hFFFF_FFFF},          34};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'd2,          {32'd1, 32'h7FFF_FFFF},          34};
    vecs[8] = '{1'b1, 32'hFFFF_FFFF,  32'd2,          {32'hFFFF_FFFF, 32'h0},          34};
    vecs[9] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'd14},         34};

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table. Each expected value is also cross-checked against the model.
    for (int i = 0; i < 10; i++) begin
      check("table_vs_model", ref_div(vecs[i].sgn, vecs[i].a, vecs[i].b), vecs[i].res);
      check("table_lat", 64'(ref_lat(vecs[i].b)), 64'(vecs[i].lat));
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, (i == 0) ? 3 : 1);
    end

    // Annul at iteration 10: go straight back to idle, and no result is produced.
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_ready", {63'd0, ready_o}, 64'd0);
    ready_seen = 0;
    for (int k = 0; k < W + 8; k++) begin
      @(negedge clk);
      if (ready_o) ready_seen++;
    end
    check("annul_no_result", 64'(ready_seen), 64'd0);
    $display("txn annul at iteration 10 ready_seen=%0d", ready_seen);
    run_div(1'b0, 32'd50, 32'd5, 1);

    // Reset at iteration 20.
    signed_div_i = 1'b1; opdata1_i = 32'hFFFF_0000; opdata2_i = 32'd9; start_i = 1'b1;
    @(posedge clk);
    repeat (20) @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", {63'd0, ready_o}, 64'd0);
    check("midrst_result", result_o, 64'd0);
    ready_seen = 0;
    for (int k = 0; k < W + 8; k++) begin
      @(negedge clk);
      if (ready_o) ready_seen++;
    end
    check("midrst_idle", 64'(ready_seen), 64'd0);
    $display("txn reset at iteration 20 ready_seen=%0d", ready_seen);
    run_div(1'b0, 32'd100, 32'd7, 3);

    // Randomized transactions, with a bias toward edge-case operands.
    for (int i = 0; i < 30; i++) begin
      sgn_r = 1'($urandom_range(0, 1));
      a_r   = $urandom;
      case ($urandom_range(0, 5))
        0:       b_r = '0;
        1:       b_r = 32'($urandom_range(1, 15));
        2:       b_r = -32'($urandom_range(1, 15));
        3:       b_r = 32'hFFFF_FFFF;
        default: b_r = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a_r = 32'h8000_0000;
      run_div(sgn_r, a_r, b_r, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
